// File: rtl/bit_timer_pkg.sv
// Purpose: shared types and limits for the configurable bit/packet timer.
// Latency: n/a (types, constants and a clamp helper only).
// Backpressure: n/a.
package bit_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  // Shortest legal bit period and packet length; smaller requests are raised to these.
  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned MIN_BITS   = 1;

  function automatic int unsigned clamp_min(input int unsigned value, input int unsigned lo);
    return (value < lo) ? lo : value;
  endfunction

endpackage

// File: rtl/sync_flex_counter.sv
// Purpose: up-counter with sync clear, count enable and runtime rollover value.
// Latency: count updates one edge after count_enable; rollover_flag is a same-cycle decode.
// Backpressure: none; counts whenever count_enable is high.
// Ports: clk, rst (sync, active-high), clear (wins over count_enable), count_enable,
//        rollover_val (count value that rolls over to 1), count_out, rollover_flag.
module sync_flex_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign rollover_flag = (count_q == rollover_val);
  assign count_out     = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      // Rolling over to 1 (not 0) keeps the count 1-based within each interval.
      count_d = rollover_flag ? WIDTH'(1) : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/param_bit_timer.sv
// Purpose: runtime-configurable bit/packet timer for the serial receive path.
// Latency: first shift_enable P cycles after enable_timer is sampled; outputs decoded from flops.
// Backpressure: none; enable_timer low aborts the packet and gates shift_enable that same cycle.
// Ports: clk, n_rst (sync, active-high), enable_timer, bit_period, num_bits (sampled at packet
//        start and at each packet_done), shift_enable, packet_done, bit_index, busy.
// Option: define HALF_FIRST_BIT_EN to shorten the first bit of each packet to ceil(period/2).
module param_bit_timer #(
  parameter int CNT_BITS     = 8,
  parameter int BIT_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    enable_timer,
  input  logic [CNT_BITS-1:0]     bit_period,
  input  logic [BIT_CNT_BITS-1:0] num_bits,
  output logic                    shift_enable,
  output logic                    packet_done,
  output logic [BIT_CNT_BITS-1:0] bit_index,
  output logic                    busy
);

  import bit_timer_pkg::*;

  timer_state_t            state_q, state_d;
  logic [CNT_BITS-1:0]     period_q, period_d;
  logic [BIT_CNT_BITS-1:0] nbits_q, nbits_d;

  logic [CNT_BITS-1:0]     clk_cnt;
  logic [CNT_BITS-1:0]     clk_target;
  logic [BIT_CNT_BITS-1:0] bit_cnt;
  logic [BIT_CNT_BITS-1:0] last_bit;
  logic                    clk_roll;
  logic                    bit_roll;
  logic                    running;
  logic                    latch;
  logic                    shift_int;
  logic                    done_int;
  logic                    bit_clear;

`ifdef HALF_FIRST_BIT_EN
  // One extra bit so period_q + 1 cannot wrap before halving.
  logic [CNT_BITS:0]       half_sum;
`endif

  always_comb begin
    running   = (state_q == RUN);
`ifdef HALF_FIRST_BIT_EN
    half_sum   = {1'b0, period_q} + (CNT_BITS+1)'(1);
    clk_target = (bit_cnt == '0) ? half_sum[CNT_BITS:1] : period_q;
`else
    clk_target = period_q;
`endif
    last_bit  = nbits_q - BIT_CNT_BITS'(1);
    shift_int = running && enable_timer && clk_roll;
    done_int  = shift_int && bit_roll;
    // Config is captured at packet start and again at each packet end, so back-to-back
    // packets pick up new settings without passing through IDLE.
    latch     = ((state_q == IDLE) && enable_timer) || done_int;
    period_d  = latch ? CNT_BITS'(clamp_min(32'(bit_period), MIN_PERIOD)) : period_q;
    nbits_d   = latch ? BIT_CNT_BITS'(clamp_min(32'(num_bits), MIN_BITS)) : nbits_q;
    state_d   = enable_timer ? RUN : IDLE;
    bit_clear = !enable_timer || !running || done_int;
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      nbits_q  <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      nbits_q  <= nbits_d;
    end
  end

  // Clock counter: cleared while disabled; the enable edge out of IDLE moves it 0 -> 1,
  // which starts the first interval without a separate load path.
  sync_flex_counter #(.WIDTH(CNT_BITS)) u_clk_cnt (
    .clk           (clk),
    .rst           (n_rst),
    .clear         (!enable_timer),
    .count_enable  (enable_timer),
    .rollover_val  (clk_target),
    .count_out     (clk_cnt),
    .rollover_flag (clk_roll)
  );

  // Bit counter: advances per shift; packet end clears it rather than rolling over.
  sync_flex_counter #(.WIDTH(BIT_CNT_BITS)) u_bit_cnt (
    .clk           (clk),
    .rst           (n_rst),
    .clear         (bit_clear),
    .count_enable  (shift_int),
    .rollover_val  (last_bit),
    .count_out     (bit_cnt),
    .rollover_flag (bit_roll)
  );

  assign shift_enable = shift_int;
  assign packet_done  = done_int;
  assign bit_index    = bit_cnt;
  assign busy         = running;

endmodule

// File: tb/tb_param_bit_timer.sv
// Purpose: scoreboard bench for param_bit_timer against an interval-arithmetic reference model.
// Latency: expectations are queued per output cycle before that cycle's stimulus is driven.
// Backpressure: n/a.
module tb_param_bit_timer;

  localparam int MAXC = 6000;

`ifdef HALF_FIRST_BIT_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  typedef struct packed {
    logic       shift;
    logic       done;
    logic [3:0] idx;
    logic       busy;
  } obs_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       enable_timer;
  logic [7:0] bit_period;
  logic [3:0] num_bits;
  logic       shift_enable;
  logic       packet_done;
  logic [3:0] bit_index;
  logic       busy;

  param_bit_timer #(.CNT_BITS(8), .BIT_CNT_BITS(4)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .bit_period   (bit_period),
    .num_bits     (num_bits),
    .shift_enable (shift_enable),
    .packet_done  (packet_done),
    .bit_index    (bit_index),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Input plan: entry c is what is driven during cycle c (seen by edge c+1).
  logic       en_a [MAXC];
  logic       rst_a[MAXC];
  logic [7:0] bp_a [MAXC];
  logic [3:0] nb_a [MAXC];
  obs_t       exp_a[MAXC];
  int         nplan   = 0;
  int         pushed  = 0;
  int         drv_cur = 0;

  int   exp_cyc_q[$];
  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic plan(input int len, input logic en, input logic [7:0] bp, input logic [3:0] nb);
    for (int i = 0; i < len; i++) begin
      if (nplan < MAXC) begin
        en_a[nplan]  = en;
        rst_a[nplan] = 1'b0;
        bp_a[nplan]  = bp;
        nb_a[nplan]  = nb;
        nplan++;
      end
    end
  endtask

  // Reference: a run begins at the first edge that sees enable high; each packet
  // takes its config from the inputs present at the edge that starts it, and its bits
  // are back-to-back intervals of P clocks (optionally ceil(P/2) for the first bit).
  // A shift only appears while enable is still high in that cycle.
  task automatic model(input int n);
    int  e, k, j, s, c, cum, p, nb, iv, first;
    bit  stop;
    for (int i = 0; i < n; i++) exp_a[i] = '0;
    e = 1;
    while (e < n) begin
      if (rst_a[e-1] || !en_a[e-1]) begin
        e++;
      end else begin
        k = e;
        j = e - 1;
        while (j + 1 < n && en_a[j+1] && !rst_a[j+1]) j++;
        for (int c2 = k; c2 <= j + 1 && c2 < n; c2++) exp_a[c2].busy = 1'b1;
        s    = k;
        stop = 1'b0;
        c    = s;
        while (!stop) begin
          p     = (int'(bp_a[s-1]) < 2) ? 2 : int'(bp_a[s-1]);
          nb    = (int'(nb_a[s-1]) < 1) ? 1 : int'(nb_a[s-1]);
          first = s;
          cum   = 0;
          for (int b = 0; b < nb && !stop; b++) begin
            iv  = (HALF && b == 0) ? (p + 1) / 2 : p;
            cum = cum + iv;
            c   = s + cum - 1;
            for (int c2 = first; c2 <= c && c2 <= j + 1 && c2 < n; c2++) exp_a[c2].idx = 4'(b);
            if (c > j) begin
              stop = 1'b1;
            end else begin
              exp_a[c].shift = 1'b1;
              exp_a[c].done  = (b == nb - 1);
              first = c + 1;
            end
          end
          if (!stop) s = c + 1;
        end
        e = j + 2;
      end
    end
  endtask

  task automatic push_phase();
    model(nplan);
    while (pushed < nplan) begin
      if (pushed >= 1) begin
        exp_cyc_q.push_back(pushed);
        exp_q.push_back(exp_a[pushed]);
      end
      pushed++;
    end
  endtask

  task automatic drive_to(input int n);
    while (drv_cur < n) begin
      n_rst        = rst_a[drv_cur];
      enable_timer = en_a[drv_cur];
      bit_period   = bp_a[drv_cur];
      num_bits     = nb_a[drv_cur];
      @(posedge clk);
      #1;
      drv_cur++;
    end
  endtask

  function automatic logic [7:0] pick_bp();
    int unsigned v;
    v = $urandom_range(0, 20);
    return (v == 20) ? 8'd255 : 8'(v % 13);
  endfunction

  // Monitor: every output cycle that has a queued expectation is compared.
  obs_t mon_got, mon_exp;
  always @(negedge clk) begin
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      mon_exp = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      mon_got = {shift_enable, packet_done, bit_index, busy};
      n_checks++;
      if (mon_got === mon_exp) begin
        n_pass++;
      end else begin
        $display("FAIL cycle %0d: got shift=%0b done=%0b idx=%0d busy=%0b, expected shift=%0b done=%0b idx=%0d busy=%0b",
                 cyc, mon_got.shift, mon_got.done, mon_got.idx, mon_got.busy,
                 mon_exp.shift, mon_exp.done, mon_exp.idx, mon_exp.busy);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rbp;
    logic [3:0] rnb;
    int         len;

    // Reset held with enable high, then enable held across back-to-back packets.
    plan(2, 1'b1, 8'd10, 4'd9);
    rst_a[0] = 1'b1;
    rst_a[1] = 1'b1;
    plan(200, 1'b1, 8'd10, 4'd9);
    plan(3, 1'b0, 8'd10, 4'd9);
    push_phase();
    drive_to(nplan);

    // Abort after the 4th shift, then restart with a full first interval.
    plan(42, 1'b1, 8'd10, 4'd9);
    plan(2, 1'b0, 8'd10, 4'd9);
    plan(30, 1'b1, 8'd10, 4'd9);
    plan(2, 1'b0, 8'd10, 4'd9);
    push_phase();
    drive_to(nplan);

    // Zero config: period behaves as 2, every shift ends a packet.
    plan(20, 1'b1, 8'd0, 4'd0);
    plan(2, 1'b0, 8'd0, 4'd0);
    // Mid-packet config change only applies from the next packet.
    plan(6, 1'b1, 8'd4, 4'd3);
    plan(40, 1'b1, 8'd7, 4'd2);
    plan(2, 1'b0, 8'd7, 4'd2);
    // Short packets: 10 clocks, 3 bits.
    plan(35, 1'b1, 8'd10, 4'd3);
    plan(2, 1'b0, 8'd10, 4'd3);
    // Single-cycle enable drop between two runs.
    plan(15, 1'b1, 8'd3, 4'd2);
    plan(1, 1'b0, 8'd3, 4'd2);
    plan(15, 1'b1, 8'd5, 4'd2);
    plan(1, 1'b0, 8'd5, 4'd2);
    push_phase();
    drive_to(nplan);

    for (int ph = 0; ph < 25; ph++) begin
      rbp = pick_bp();
      rnb = 4'($urandom_range(0, 15));
      plan(int'($urandom_range(1, 4)), 1'b0, rbp, rnb);
      len = int'($urandom_range(1, 90));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          rbp = pick_bp();
          rnb = 4'($urandom_range(0, 15));
        end
        plan(1, 1'b1, rbp, rnb);
      end
      plan(1, 1'b0, rbp, rnb);
      push_phase();
      drive_to(nplan);
    end

    for (int i = 0; i < 10 && exp_cyc_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_cyc_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: %0d expectations left, required 0", exp_cyc_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
